// File: rtl/bp_cfg_link_loader.sv
// Config-link boot initiator: issues the fixed reset/freeze/id/npc/mode/ucode/unfreeze
// write sequence onto the cfg link, one write in flight, advancing on each transfer.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for start after reset
// RST_ON   | write 'h0001 <- 1
// FRZ      | write 'h0002 <- 1
// RST_OFF  | write 'h0001 <- 0
// CID      | write 'h0005 <- latched core id
// NPC_LO   | write 'h0040 <- latched npc low word
// NPC_HI   | write 'h0041 <- latched npc high word
// MODE     | write 'h0081 <- cce_mode_p
// UCODE    | stream ucode words to 'h8000+cnt, valid follows source
// UNFRZ    | write 'h0002 <- 0
// DONE     | sequence complete, waiting for restart
module bp_cfg_link_loader #(
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int num_cce_ucode_p  = 256,
  parameter int cce_mode_p       = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  input  logic [cfg_data_width_p-1:0]   core_id_i,
  input  logic [2*cfg_data_width_p-1:0] npc_i,
  input  logic                          ucode_v_i,
  input  logic [cfg_data_width_p-1:0]   ucode_data_i,
  output logic                          ucode_yumi_o,
  output logic                          cfg_v_o,
  output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
  output logic [cfg_data_width_p-1:0]   cfg_data_o,
  input  logic                          cfg_ready_i,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int AW   = cfg_addr_width_p;
  localparam int DW   = cfg_data_width_p;
  localparam int CntW = (num_cce_ucode_p > 0) ? $clog2(num_cce_ucode_p + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_ON, S_FRZ, S_RST_OFF, S_CID, S_NPC_LO,
    S_NPC_HI, S_MODE, S_UCODE, S_UNFRZ, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [DW-1:0]     core_id_q;
  logic [2*DW-1:0]   npc_q;
  logic              cfg_v_q, done_q;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              in_ucode, xfer;

  assign in_ucode     = (state_q == S_UCODE);
  assign cfg_v_o      = in_ucode ? ucode_v_i : cfg_v_q;
  assign cfg_addr_o   = in_ucode ? (AW'('h8000) + AW'(cnt_q)) : addr_q;
  assign cfg_data_o   = in_ucode ? ucode_data_i : data_q;
  assign xfer         = cfg_v_o & cfg_ready_i;
  assign ucode_yumi_o = in_ucode & ucode_v_i & cfg_ready_i;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = done_q;

  // Successor state and the write it presents, loaded on the advancing edge.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    data_d  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin state_d = S_RST_ON;  addr_d = AW'('h0001); data_d = DW'(1); end
      S_RST_ON:       begin state_d = S_FRZ;     addr_d = AW'('h0002); data_d = DW'(1); end
      S_FRZ:          begin state_d = S_RST_OFF; addr_d = AW'('h0001); data_d = DW'(0); end
      S_RST_OFF:      begin state_d = S_CID;     addr_d = AW'('h0005); data_d = core_id_q; end
      S_CID:          begin state_d = S_NPC_LO;  addr_d = AW'('h0040); data_d = npc_q[DW-1:0]; end
      S_NPC_LO:       begin state_d = S_NPC_HI;  addr_d = AW'('h0041); data_d = npc_q[2*DW-1:DW]; end
      S_NPC_HI:       begin state_d = S_MODE;    addr_d = AW'('h0081); data_d = DW'(cce_mode_p); end
      S_MODE: begin
        if (num_cce_ucode_p > 0) begin
          state_d = S_UCODE;
        end else begin
          state_d = S_UNFRZ;
          addr_d  = AW'('h0002);
        end
      end
      S_UCODE:        begin state_d = S_UNFRZ;   addr_d = AW'('h0002); data_d = DW'(0); end
      S_UNFRZ:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      core_id_q <= '0;
      npc_q     <= '0;
      cfg_v_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            core_id_q <= core_id_i;
            npc_q     <= npc_i;
            done_q    <= 1'b0;
            state_q   <= state_d;
            cfg_v_q   <= 1'b1;
            addr_q    <= addr_d;
            data_q    <= data_d;
          end
        end
        S_UCODE: begin
          if (xfer) begin
            if (cnt_q == CntW'(num_cce_ucode_p - 1)) begin
              cnt_q   <= '0;
              state_q <= state_d;
              cfg_v_q <= 1'b1;
              addr_q  <= addr_d;
              data_q  <= data_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          if (xfer) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // UCODE drives valid from the source; DONE has nothing to send.
            cfg_v_q <= !(state_d == S_UCODE || state_d == S_DONE);
            done_q  <= (state_d == S_DONE);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// Directed bench for bp_cfg_link_loader: one instance with 4 ucode words, one with none;
// observed transfers are collected at negedge and compared to hand-built write lists.
module tb_bp_cfg_link_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start4 = 1'b0, start0 = 1'b0;
  logic [31:0] core_id = '0;
  logic [63:0] npc_in = '0;
  logic        ucode_v = 1'b0;
  logic [31:0] ucode_data;
  logic        cfg_ready = 1'b0;

  logic        yumi4, v4, busy4, done4;
  logic [15:0] addr4;
  logic [31:0] data4;
  logic        yumi0, v0, busy0, done0;
  logic [15:0] addr0;
  logic [31:0] data0;

  int n_checks = 0, n_err = 0;
  int uword4 = 0, yumi4_total = 0, yumi0_total = 0;
  logic [47:0] q4[$], q0[$], exp_q[$];
  bit          stab_en = 0, gap_en = 0, held = 0;
  logic [47:0] held_w = '0;

  always #5 clk = ~clk;

  assign ucode_data = 32'hC0DE_0000 + uword4;

  bp_cfg_link_loader #(.num_cce_ucode_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start4), .core_id_i(core_id),
    .npc_i(npc_in), .ucode_v_i(ucode_v), .ucode_data_i(ucode_data),
    .ucode_yumi_o(yumi4), .cfg_v_o(v4), .cfg_addr_o(addr4), .cfg_data_o(data4),
    .cfg_ready_i(cfg_ready), .busy_o(busy4), .done_o(done4));

  bp_cfg_link_loader #(.num_cce_ucode_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start0), .core_id_i(core_id),
    .npc_i(npc_in), .ucode_v_i(ucode_v), .ucode_data_i(ucode_data),
    .ucode_yumi_o(yumi0), .cfg_v_o(v0), .cfg_addr_o(addr0), .cfg_data_o(data0),
    .cfg_ready_i(cfg_ready), .busy_o(busy0), .done_o(done0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (yumi4) uword4 <= uword4 + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (v4 && cfg_ready) q4.push_back({addr4, data4});
      if (v0 && cfg_ready) q0.push_back({addr0, data0});
      if (yumi4) yumi4_total++;
      if (yumi0) yumi0_total++;
      if (stab_en && held) check("hold_stable", {v4, addr4, data4}, {1'b1, held_w});
      held   = v4 && !cfg_ready;
      held_w = {addr4, data4};
      if (gap_en && addr4[15] && !ucode_v) check("ucode_gap_v", v4, 1'b0);
    end
  end

  task automatic build_exp(input logic [31:0] core, input logic [63:0] npc, input int n,
                           input logic [31:0] ubase);
    exp_q.delete();
    exp_q.push_back({16'h0001, 32'd1});
    exp_q.push_back({16'h0002, 32'd1});
    exp_q.push_back({16'h0001, 32'd0});
    exp_q.push_back({16'h0005, core});
    exp_q.push_back({16'h0040, npc[31:0]});
    exp_q.push_back({16'h0041, npc[63:32]});
    exp_q.push_back({16'h0081, 32'd1});
    for (int i = 0; i < n; i++) exp_q.push_back({16'h8000 + 16'(i), ubase + 32'(i)});
    exp_q.push_back({16'h0002, 32'd0});
  endtask

  task automatic cmp_writes(input string tag, input bit use0);
    logic [47:0] obs[$];
    if (use0) obs = q0; else obs = q4;
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s_w%0d", tag, i), obs[i], exp_q[i]);
  endtask

  task automatic kick(input bit use0, input logic [31:0] core, input logic [63:0] npc);
    @(posedge clk); #1;
    core_id = core; npc_in = npc;
    if (use0) start0 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start4 = 1'b0;
    core_id = 32'hDEAD_BEEF; npc_in = ~npc;
  endtask

  task automatic run_seq(input bit use0, input int budget, input bit tog, input bit gap);
    int cyc = 0;
    bit d = 0;
    while (!d && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      cfg_ready = tog ? ~cfg_ready : 1'b1;
      ucode_v   = gap ? (cyc % 4 == 0) : 1'b1;
      d = use0 ? done0 : done4;
    end
    check("seq_timeout", d, 1'b1);
  endtask

  initial begin
    logic [31:0] ubase;
    int          y0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_v", v4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_addr_data", {addr4, data4}, 48'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Back-to-back sequence, exact cycle timing, inputs changed after start.
    cfg_ready = 1'b1; ucode_v = 1'b1;
    q4.delete(); ubase = 32'hC0DE_0000 + uword4;
    build_exp(32'd3, 64'h0000_0001_8000_0000, 4, ubase);
    kick(0, 32'd3, 64'h0000_0001_8000_0000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("t1_v_cyc%0d", i + 1), v4, 1'b1);
      if (i == 0) check("t1_busy", busy4, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_done_cyc13", done4, 1'b1);
    check("t1_busy_end", busy4, 1'b0);
    cmp_writes("t1", 0);

    // Ready toggling every cycle.
    q4.delete(); ubase = 32'hC0DE_0000 + uword4;
    build_exp(32'h0000_00A5, 64'h1234_5678_9ABC_DEF0, 4, ubase);
    stab_en = 1;
    kick(0, 32'h0000_00A5, 64'h1234_5678_9ABC_DEF0);
    run_seq(0, 100, 1, 0);
    @(negedge clk);
    stab_en = 0;
    cmp_writes("t3", 0);

    // Ucode source with 3-cycle gaps.
    cfg_ready = 1'b1;
    q4.delete(); ubase = 32'hC0DE_0000 + uword4; y0 = yumi4_total;
    build_exp(32'd7, 64'h0, 4, ubase);
    gap_en = 1;
    kick(0, 32'd7, 64'h0);
    run_seq(0, 100, 0, 1);
    @(negedge clk);
    gap_en = 0;
    cmp_writes("t4", 0);
    check("t4_yumi_count", yumi4_total - y0, 4);

    // Reset during NPC_HI, no resume, then full replay.
    cfg_ready = 1'b1; ucode_v = 1'b1;
    kick(0, 32'd9, 64'hFFFF_0000_0000_FFFF);
    begin
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        hit = v4 && (addr4 == 16'h0041);
      end
      check("t5_reach_npc_hi", hit, 1'b1);
    end
    reset_n = 1'b0; #1;
    check("t5_rst_v", v4, 1'b0);
    check("t5_rst_busy", busy4, 1'b0);
    check("t5_rst_done", done4, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    q4.delete();
    repeat (10) @(posedge clk);
    #1;
    check("t5_idle_writes", q4.size(), 0);
    check("t5_idle_busy", busy4, 1'b0);
    ubase = 32'hC0DE_0000 + uword4;
    build_exp(32'd9, 64'hFFFF_0000_0000_FFFF, 4, ubase);
    kick(0, 32'd9, 64'hFFFF_0000_0000_FFFF);
    run_seq(0, 100, 0, 0);
    @(negedge clk);
    cmp_writes("t5", 0);

    // No-ucode build: start while busy ignored, restart from DONE.
    q0.delete(); y0 = yumi0_total;
    build_exp(32'd2, 64'h0000_0002_0000_1000, 0, 32'h0);
    kick(1, 32'd2, 64'h0000_0002_0000_1000);
    repeat (2) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    run_seq(1, 50, 0, 0);
    @(negedge clk);
    cmp_writes("t6a", 1);
    check("t6_done", done0, 1'b1);
    q0.delete();
    build_exp(32'd4, 64'h0000_0003_0000_2000, 0, 32'h0);
    kick(1, 32'd4, 64'h0000_0003_0000_2000);
    check("t6_done_clr", done0, 1'b0);
    check("t6_busy", busy0, 1'b1);
    run_seq(1, 50, 0, 0);
    @(negedge clk);
    cmp_writes("t6b", 1);
    check("t6_no_yumi", yumi0_total - y0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
